pc_target_calc: RTL and testbench

PC_TARGET_CALC -- requirements
Module: pc_target_calc

---
 rtl/pc_target_calc.sv | 56 +++++
 tb/tb_pc_target_calc.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_target_calc.sv
// Branch/jump target computation and PC register for a single-issue core.
// Optional stall gating is enabled with macro PC_STALL_EN.
module pc_target_calc #(
  parameter int PC_W  = 32,
  parameter int IMM_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [PC_W-1:0]   current_pc,
  input  logic [IMM_W-1:0]  IMMEDIATE,
  input  logic              BEQ_signal,
  input  logic              ZERO,
  input  logic              J_signal,
  input  logic              BUSYWAIT,
  input  logic              insWAIT,
  output logic [PC_W-1:0]   pc_plus4,
  output logic [PC_W-1:0]   offset_32,
  output logic [PC_W-1:0]   target,
  output logic [PC_W-1:0]   next_pc,
  output logic [PC_W-1:0]   insPC
);

  // -4, so the first non-stalled cycle after reset fetches address 0
  localparam logic [PC_W-1:0] RESET_PC = ~(PC_W'(3));

  logic take;
  logic stall;
  logic [PC_W-1:0] pc_sel;

  assign pc_plus4  = current_pc + PC_W'(4);
  assign offset_32 = {{(PC_W-IMM_W-2){IMMEDIATE[IMM_W-1]}}, IMMEDIATE, 2'b00};
  assign target    = pc_plus4 + offset_32;

  assign take   = (BEQ_signal & ZERO) | J_signal;
  assign pc_sel = take ? target : pc_plus4;

`ifdef PC_STALL_EN
  assign stall = BUSYWAIT | insWAIT;
`else
  // Stall requests are accepted but have no effect in this build.
  logic unused_stall_inputs;
  assign unused_stall_inputs = BUSYWAIT ^ insWAIT;
  assign stall = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      next_pc <= RESET_PC;
      insPC   <= RESET_PC;
    end else if (!stall) begin
      next_pc <= pc_sel;
      insPC   <= pc_sel;
    end
  end

endmodule

// File: tb/tb_pc_target_calc.sv
// Directed self-checking bench for pc_target_calc (default 32-bit PC, 8-bit offset).
module tb_pc_target_calc;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] current_pc;
  logic [7:0]  IMMEDIATE;
  logic        BEQ_signal, ZERO, J_signal, BUSYWAIT, insWAIT;
  logic [31:0] pc_plus4, offset_32, target, next_pc, insPC;

  int n_cmp  = 0;
  int n_fail = 0;

  pc_target_calc #(.PC_W(32), .IMM_W(8)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .current_pc (current_pc),
    .IMMEDIATE  (IMMEDIATE),
    .BEQ_signal (BEQ_signal),
    .ZERO       (ZERO),
    .J_signal   (J_signal),
    .BUSYWAIT   (BUSYWAIT),
    .insWAIT    (insWAIT),
    .pc_plus4   (pc_plus4),
    .offset_32  (offset_32),
    .target     (target),
    .next_pc    (next_pc),
    .insPC      (insPC)
  );

  always #5 CLK = ~CLK;

  // Inputs change 1ns after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [7:0] imm,
                       input logic beq, input logic z, input logic j);
    current_pc = pc;
    IMMEDIATE  = imm;
    BEQ_signal = beq;
    ZERO       = z;
    J_signal   = j;
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; BUSYWAIT = 1'b0; insWAIT = 1'b0;
    drive(32'h0000_1000, 8'h05, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (next_pc !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL reset_next_pc got=%h exp=%h", next_pc, 32'hFFFF_FFFC);
    end
    n_cmp++;
    if (insPC !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL reset_insPC got=%h exp=%h", insPC, 32'hFFFF_FFFC);
    end
    // Reset beats a taken jump and a stall request.
    drive(32'h0000_0100, 8'h10, 1'b1, 1'b1, 1'b1);
    BUSYWAIT = 1'b1; insWAIT = 1'b1;
    tick();
    n_cmp++;
    if (next_pc !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL reset_priority got=%h exp=%h", next_pc, 32'hFFFF_FFFC);
    end
    BUSYWAIT = 1'b0; insWAIT = 1'b0;
  endtask

  task automatic test_wrap();
    RESET = 1'b0;
    drive(32'hFFFF_FFFC, 8'h00, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (pc_plus4 !== 32'h0) begin
      n_fail++; $display("FAIL wrap_pc_plus4 got=%h exp=%h", pc_plus4, 32'h0);
    end
    tick();
    n_cmp++;
    if (next_pc !== 32'h0) begin
      n_fail++; $display("FAIL wrap_next_pc got=%h exp=%h", next_pc, 32'h0);
    end
    n_cmp++;
    if (insPC !== 32'h0) begin
      n_fail++; $display("FAIL wrap_insPC got=%h exp=%h", insPC, 32'h0);
    end
  endtask

  task automatic test_beq_taken();
    drive(32'h10, 8'h03, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (offset_32 !== 32'h0C) begin
      n_fail++; $display("FAIL beq_offset got=%h exp=%h", offset_32, 32'h0C);
    end
    n_cmp++;
    if (target !== 32'h20) begin
      n_fail++; $display("FAIL beq_target got=%h exp=%h", target, 32'h20);
    end
    tick();
    n_cmp++;
    if (next_pc !== 32'h20) begin
      n_fail++; $display("FAIL beq_next_pc got=%h exp=%h", next_pc, 32'h20);
    end
    n_cmp++;
    if (insPC !== 32'h20) begin
      n_fail++; $display("FAIL beq_insPC got=%h exp=%h", insPC, 32'h20);
    end
  endtask

  task automatic test_jump();
    drive(32'h10, 8'hFE, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (offset_32 !== 32'hFFFF_FFF8) begin
      n_fail++; $display("FAIL jump_offset got=%h exp=%h", offset_32, 32'hFFFF_FFF8);
    end
    n_cmp++;
    if (target !== 32'h0C) begin
      n_fail++; $display("FAIL jump_target got=%h exp=%h", target, 32'h0C);
    end
    tick();
    n_cmp++;
    if (next_pc !== 32'h0C) begin
      n_fail++; $display("FAIL jump_next_pc got=%h exp=%h", next_pc, 32'h0C);
    end
    // Jump still taken while the branch condition is false.
    drive(32'h200, 8'h04, 1'b1, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if (next_pc !== 32'h214) begin
      n_fail++; $display("FAIL jump_dominates got=%h exp=%h", next_pc, 32'h214);
    end
  endtask

  task automatic test_beq_not_taken();
    drive(32'h40, 8'h03, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (next_pc !== 32'h44) begin
      n_fail++; $display("FAIL beq_nt_next_pc got=%h exp=%h", next_pc, 32'h44);
    end
    // Zero flag alone does not take the branch.
    drive(32'h40, 8'h03, 1'b0, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (insPC !== 32'h44) begin
      n_fail++; $display("FAIL zero_only_insPC got=%h exp=%h", insPC, 32'h44);
    end
  endtask

  task automatic test_stall();
    logic [31:0] hold_exp;
    drive(32'h80, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
`ifdef PC_STALL_EN
    hold_exp = 32'h84;
`else
    hold_exp = 32'h104;
`endif
    drive(32'h100, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      BUSYWAIT = (i < 3);
      insWAIT  = (i >= 3);
      #1;
      n_cmp++;
      if (pc_plus4 !== 32'h104) begin
        n_fail++; $display("FAIL stall_comb_%0d got=%h exp=%h", i, pc_plus4, 32'h104);
      end
      tick();
      n_cmp++;
      if (next_pc !== hold_exp) begin
        n_fail++; $display("FAIL stall_next_pc_%0d got=%h exp=%h", i, next_pc, hold_exp);
      end
      n_cmp++;
      if (insPC !== hold_exp) begin
        n_fail++; $display("FAIL stall_insPC_%0d got=%h exp=%h", i, insPC, hold_exp);
      end
    end
    BUSYWAIT = 1'b0; insWAIT = 1'b0;
    tick();
    n_cmp++;
    if (next_pc !== 32'h104) begin
      n_fail++; $display("FAIL stall_release got=%h exp=%h", next_pc, 32'h104);
    end
    n_cmp++;
    if (insPC !== 32'h104) begin
      n_fail++; $display("FAIL stall_release_insPC got=%h exp=%h", insPC, 32'h104);
    end
  endtask

  task automatic test_reset_during_stall();
    BUSYWAIT = 1'b1; RESET = 1'b1;
    drive(32'h300, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (insPC !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL reset_in_stall got=%h exp=%h", insPC, 32'hFFFF_FFFC);
    end
    BUSYWAIT = 1'b0; RESET = 1'b0;
  endtask

  task automatic test_imm_bounds();
    drive(32'h0, 8'h7F, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (offset_32 !== 32'h1FC) begin
      n_fail++; $display("FAIL imm_max_offset got=%h exp=%h", offset_32, 32'h1FC);
    end
    n_cmp++;
    if (target !== 32'h200) begin
      n_fail++; $display("FAIL imm_max_target got=%h exp=%h", target, 32'h200);
    end
    drive(32'h0, 8'h80, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (offset_32 !== 32'hFFFF_FE00) begin
      n_fail++; $display("FAIL imm_min_offset got=%h exp=%h", offset_32, 32'hFFFF_FE00);
    end
    n_cmp++;
    if (target !== 32'hFFFF_FE04) begin
      n_fail++; $display("FAIL imm_min_target got=%h exp=%h", target, 32'hFFFF_FE04);
    end
    tick();
    n_cmp++;
    if (next_pc !== 32'hFFFF_FE04) begin
      n_fail++; $display("FAIL imm_min_next_pc got=%h exp=%h", next_pc, 32'hFFFF_FE04);
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_beq_taken();
    test_jump();
    test_beq_not_taken();
    test_stall();
    test_reset_during_stall();
    test_imm_bounds();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
